// File: rtl/vga_text_pkg.sv
// Shared constants and payload types for the text-mode video path.
package vga_text_pkg;

  localparam int unsigned GLYPH_W        = 8;
  localparam int unsigned GLYPH_H        = 8;
  localparam int unsigned RENDER_LATENCY = 5;
  localparam int unsigned DEF_COLS       = 80;
  localparam int unsigned DEF_ROWS       = 60;
  localparam int unsigned INV_BIT        = 7;
  localparam int unsigned GLYPH_IDX_W    = 7;

  // Side-band signals carried alongside each pixel through the pipeline.
  typedef struct packed {
    logic video;
    logic hsync;
    logic vsync;
  } side_t;

endpackage

// File: rtl/cursor_blink.sv
// Frame-tick detector and cursor blink phase generator.
module cursor_blink #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic blink_phase
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             tick_c;

  // A frame starts on each falling edge of vsync.
  always_comb begin
    vs_prev_d     = vsync_in;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    tick_c        = vs_prev_q & ~vsync_in;
    if (tick_c) begin
      if (frame_cnt_q == CNT_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q     <= 1'b1;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      vs_prev_q     <= vs_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;

endmodule

// File: rtl/text_glyph_renderer.sv
// Text-mode pixel generator: text buffer lookup, glyph fetch, serialisation and sync alignment.
module text_glyph_renderer
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned TADDR_W      = 13,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [TADDR_W-1:0] char_addr,
  input  logic [7:0]         char_code,
  output logic               rom_enable,
  output logic [9:0]         rom_address,
  input  logic [7:0]         rom_data,
  input  logic               cursor_en,
  input  logic [6:0]         cursor_col,
  input  logic [5:0]         cursor_row,
  output logic               pixel_on,
  output logic               pixel_valid,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int unsigned XLO_W = $clog2(GLYPH_W);
  localparam int unsigned YLO_W = $clog2(GLYPH_H);
  localparam int unsigned DEPTH = RENDER_LATENCY;
  localparam side_t SIDE_IDLE = '{video: 1'b0, hsync: 1'b1, vsync: 1'b1};

  if (COLS * ROWS > (32'd1 << TADDR_W)) begin : g_addr_range
    $error("text buffer does not fit in TADDR_W address bits");
  end

  logic [9-XLO_W:0]   col_c;
  logic [9-YLO_W:0]   row_c;
  logic [TADDR_W-1:0] char_addr_q, char_addr_d;
  logic [9:0]         rom_address_q, rom_address_d;
  logic               rom_enable_q, rom_enable_d;
  logic               pixel_on_q, pixel_on_d;
  side_t              side_q [DEPTH];
  side_t              side_d [DEPTH];
  logic [XLO_W-1:0]   x_lo_q [4];
  logic [XLO_W-1:0]   x_lo_d [4];
  logic [YLO_W-1:0]   y_lo_q [2];
  logic [YLO_W-1:0]   y_lo_d [2];
  logic               hit_q  [4];
  logic               hit_d  [4];
  logic               inv_q  [2];
  logic               inv_d  [2];
  logic               blink_phase;

  cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_in    (vsync_in),
    .blink_phase (blink_phase)
  );

  // Next-state for every pipeline stage; stage index 0 is captured at edge 1.
  always_comb begin
    col_c       = pixel_x[9:XLO_W];
    row_c       = pixel_y[9:YLO_W];
    char_addr_d = video_on ? TADDR_W'(32'(row_c) * COLS + 32'(col_c)) : '0;

    side_d[0] = '{video: video_on, hsync: hsync_in, vsync: vsync_in};
    for (int i = 1; i < DEPTH; i++) side_d[i] = side_q[i-1];

    // cursor_en is folded in here so later changes do not affect pixels in flight
    x_lo_d[0] = pixel_x[XLO_W-1:0];
    y_lo_d[0] = pixel_y[YLO_W-1:0];
    hit_d[0]  = cursor_en & (col_c == cursor_col) & (row_c == {1'b0, cursor_row});
    for (int i = 1; i < 4; i++) begin
      x_lo_d[i] = x_lo_q[i-1];
      hit_d[i]  = hit_q[i-1];
    end
    y_lo_d[1] = y_lo_q[0];

    rom_address_d = {char_code[GLYPH_IDX_W-1:0], y_lo_q[1]};
    rom_enable_d  = side_q[1].video;
    inv_d[0]      = char_code[INV_BIT];
    inv_d[1]      = inv_q[0];

    // Bit 7 is the leftmost pixel, so the column offset selects bit ~x_lo.
    pixel_on_d = side_q[3].video &
                 (rom_data[~x_lo_q[3]] ^ inv_q[1] ^ (hit_q[3] & blink_phase));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr_q   <= '0;
      rom_address_q <= '0;
      rom_enable_q  <= 1'b0;
      pixel_on_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) side_q[i] <= SIDE_IDLE;
      for (int i = 0; i < 4; i++) begin
        x_lo_q[i] <= '0;
        hit_q[i]  <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        y_lo_q[i] <= '0;
        inv_q[i]  <= 1'b0;
      end
    end else begin
      char_addr_q   <= char_addr_d;
      rom_address_q <= rom_address_d;
      rom_enable_q  <= rom_enable_d;
      pixel_on_q    <= pixel_on_d;
      side_q        <= side_d;
      x_lo_q        <= x_lo_d;
      hit_q         <= hit_d;
      y_lo_q        <= y_lo_d;
      inv_q         <= inv_d;
    end
  end

  assign char_addr   = char_addr_q;
  assign rom_address = rom_address_q;
  assign rom_enable  = rom_enable_q;
  assign pixel_on    = pixel_on_q;
  assign pixel_valid = side_q[DEPTH-1].video;
  assign hsync_out   = side_q[DEPTH-1].hsync;
  assign vsync_out   = side_q[DEPTH-1].vsync;

endmodule

// File: doc/text_glyph_renderer.md
# text_glyph_renderer

Text-mode pixel generator between the VGA timing generator and the colour output stage. For each pixel coordinate it reads the character code from the text buffer and fetches the matching glyph row from the glyph ROM. It serialises that row into a 1-bit pixel stream, applies the inverse attribute and a blinking cursor, and delays hsync/vsync so they stay aligned with the pixels. It is the read-side client of the glyph ROM (1024 × 8, 128 glyphs × 8 rows, registered output, 1-cycle latency, enable-gated).

## Interface
- COLS, 80: character columns per line
- ROWS, 60: character rows per frame
- TADDR_W, 13: text buffer address width
- BLINK_FRAMES, 30: vsync periods per cursor blink half-period (≥1)

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pixel_x  in  10  current pixel column from timing generator
- pixel_y  in  10  current pixel row
- video_on  in  1  active-display flag
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- char_addr  out  TADDR_W  text buffer read address (buffer has 1-cycle sync read)
- char_code  in  8  text buffer data; [6:0] glyph index, [7] inverse attribute
- rom_enable  out  1  glyph ROM read enable
- rom_address  out  10  glyph ROM address
- rom_data  in  8  glyph ROM row data; bit 7 is the leftmost pixel
- cursor_en  in  1  cursor display enable
- cursor_col  in  7  cursor column
- cursor_row  in  6  cursor row
- pixel_on  out  1  foreground pixel
- pixel_valid  out  1  delayed video_on
- hsync_out  out  1  hsync delayed to match pixel_on
- vsync_out  out  1  vsync delayed to match pixel_on

## Operation
- Stage 1, edge 1:
  - col = pixel_x[9:3], row = pixel_y[9:3].
  - char_addr ← row*COLS + col, truncated to TADDR_W. Shift-add is permitted for COLS = 80.
  - When video_on = 0, char_addr ← 0.
  - Capture x_lo = pixel_x[2:0], y_lo = pixel_y[2:0], and cursor_hit = (col == cursor_col) && (row == cursor_row).
- Stage 2, edge 2: the text buffer presents char_code.
- Stage 3, edge 3:
  - rom_address ← {char_code[6:0], y_lo}.
  - rom_enable ← delayed video_on.
  - Capture inv = char_code[7].
- Stage 4, edge 4: the ROM presents rom_data. If rom_enable was low, the ROM holds its data; the renderer masks it.
- Stage 5, edge 5:
  - pixel_on ← v5 & (rom_data[7 − x_lo] ^ inv ^ (cursor_hit & cursor_en & blink_phase)).
  - v5 is video_on delayed to stage 5.
- Side-band signals: video_on, hsync_in and vsync_in pass through a 5-deep shift register to produce pixel_valid, hsync_out and vsync_out.
- Blink counter:
  - A frame tick is vsync_in sampled 1 → 0.
  - frame_cnt counts from 0 to BLINK_FRAMES−1. At wrap it returns to 0 and blink_phase toggles.
  - frame_cnt width is ceil(log2(BLINK_FRAMES)), minimum 1.

## Timing
- Latency is exactly 5 clk edges from pixel_x/pixel_y/syncs to pixel_on/pixel_valid/hsync_out/vsync_out. It is constant and has no stalls.
- Reset values:
  - char_addr, rom_address, rom_enable, pixel_on, pixel_valid, frame_cnt: 0.
  - hsync_out, vsync_out, and all internal sync delay flops: 1 (idle).
  - blink_phase: 1, so the cursor is visible immediately.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. After release, pixel_valid stays 0 for the first 5 edges while the pipeline refills.
- Throughput is one pixel per clock. Glyph index and row change at every x_lo = 0 and y_lo = 0 boundary with no gap.
- pixel_y ≥ ROWS*8 or pixel_x ≥ COLS*8 with video_on = 1 is undefined input. The address is truncated and no wrap protection is applied.
- A frame tick on the same cycle as reset release is ignored.
- cursor_en, cursor_col and cursor_row are sampled in stage 1 only. A change mid-character takes effect per pixel at that stage.

## Structure
- Shared package vga_text_pkg holds:
  - constants GLYPH_W = 8, GLYPH_H = 8, RENDER_LATENCY = 5;
  - default COLS/ROWS;
  - the char_code field positions (INV_BIT = 7, glyph index [6:0]).
- Sub-module cursor_blink holds the frame-tick edge detector, frame_cnt and blink_phase. It takes the BLINK_FRAMES parameter and outputs blink_phase.
- The main module holds the address arithmetic, the pipeline registers and the bit select.

## Test plan
- Cell (0,0) = 8'h41, ROM word 10'h208 = 8'b00011000, pixel_y = 0, pixel_x = 0..7, video_on = 1:
  - rom_address = 10'h208 with rom_enable = 1 at edge 3;
  - pixel_on = 0,0,0,1,1,0,0,0 starting at edge 5.
- Same cell with code 8'hC1: pixel_on = 1,1,1,0,0,1,1,1.
- pixel_x = 639, pixel_y = 479: char_addr = 4799 (13'h12BF) at edge 1. With video_on = 0: char_addr = 0, rom_enable = 0, and pixel_on = 0 five cycles later.
- BLINK_FRAMES = 2, cursor_en = 1, cursor at (0,0), glyph 8'h00:
  - pixel_on is all 1 in cell (0,0) for frames 0–1;
  - all 0 for frames 2–3, counted by vsync_in falling edges;
  - the cursor is suppressed when cursor_en = 0.
- Sync alignment: random pixel stream with hsync_in pulses. hsync_out, vsync_out and pixel_valid equal their inputs delayed exactly 5 cycles, checked against a reference model.
- Assert rst_n low mid-line:
  - outputs are at reset values before the next clk edge;
  - after release, pixel_valid = 0 for 5 edges, then tracks video_on.
